// File: rtl/btb_pkg.sv
// BTB shared definitions: entry layout, controller states and entry helpers.
// Entry = {valid, tag, target[31:2], 2-bit counter}.
package btb_pkg;

  localparam int INDEX_W = 7;
  localparam int TAG_W   = 23;
  localparam int TGT_W   = 30;
  localparam int ENTRY_W = 56;

  localparam int VLD_B  = 55;
  localparam int TAG_HI = 54;
  localparam int TAG_LO = 32;
  localparam int TGT_HI = 31;
  localparam int TGT_LO = 2;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RD,
    MOD
  } state_t;

  function automatic logic [1:0] ctr_next(
    input logic [1:0] c,
    input logic       t
  );
    if (t)
      return (c == 2'b11) ? c : c + 2'd1;
    else
      return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [ENTRY_W-1:0] entry_pack(
    input logic             v,
    input logic [TAG_W-1:0] tag,
    input logic [TGT_W-1:0] tgt,
    input logic [1:0]       ctr
  );
    return {v, tag, tgt, ctr};
  endfunction

endpackage

// File: rtl/dual_port_RAM.sv
// Two-clock RAM: port A read-only lookup port, port B read/byte-write.
// Registered outputs with synchronous reset; port B is read-first.
module dual_port_RAM #(
  parameter int DATA_WIDTH = 56,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                    clka,
  input  logic                    clkb,
  input  logic                    ena,
  input  logic                    enb,
  input  logic                    rsta,
  input  logic                    rstb,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [DATA_WIDTH/8-1:0] web,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  input  logic [DATA_WIDTH-1:0]   dina,
  input  logic [DATA_WIDTH-1:0]   dinb,
  output logic [DATA_WIDTH-1:0]   douta,
  output logic [DATA_WIDTH-1:0]   doutb
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Port A carries no write path in this configuration.
  logic unused_a;
  assign unused_a = ^{wea, dina};

  always_ff @(posedge clka) begin
    if (rsta)
      douta <= '0;
    else if (ena)
      douta <= mem[addra];
  end

  always_ff @(posedge clkb) begin
    if (rstb)
      doutb <= '0;
    else if (enb)
      doutb <= mem[addrb];
  end

  always_ff @(posedge clkb) begin
    if (enb) begin
      for (int b = 0; b < NB; b++)
        if (web[b])
          mem[addrb][b*8 +: 8] <= dinb[b*8 +: 8];
    end
  end

endmodule

// File: rtl/btb_ctrl.sv
// BTB controller: 1-cycle lookups on port A, RMW updates on port B,
// table clear after reset and flush.
module btb_ctrl
  import btb_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  output logic        rsp_valid,
  output logic        rsp_hit,
  output logic        rsp_taken,
  output logic [31:0] rsp_target,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        init_busy
);

  state_t state, state_nx;
  logic [INDEX_W-1:0] clr_idx, clr_nx;

  logic [29:0]      cap_pc;
  logic             cap_taken;
  logic [TGT_W-1:0] cap_tgt;

  logic [ENTRY_W/8-1:0] web;
  logic [INDEX_W-1:0]   addrb;
  logic [ENTRY_W-1:0]   dinb, douta, doutb;
  logic [ENTRY_W-1:0]   new_ent;
  logic                 do_wr;

  logic               lk_q, blk_q, fwd_q;
  logic [TAG_W-1:0]   lk_tag_q;
  logic [ENTRY_W-1:0] fwd_d_q, ent;
  logic               hit;

  wire [TAG_W-1:0] cap_tag = cap_pc[29:INDEX_W];
  wire             accept  = upd_valid & upd_ready & ~flush;

  logic unused_lsb;
  assign unused_lsb = ^{lk_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  dual_port_RAM #(
    .DATA_WIDTH(ENTRY_W),
    .ADDR_WIDTH(INDEX_W)
  ) u_btb_ram (
    .clka (clk),
    .clkb (clk),
    .ena  (1'b1),
    .enb  (1'b1),
    .rsta (~rstn),
    .rstb (~rstn),
    .wea  ('0),
    .web  (web),
    .addra(lk_pc[8:2]),
    .addrb(addrb),
    .dina ('0),
    .dinb (dinb),
    .douta(douta),
    .doutb(doutb)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= INIT;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cap_pc    <= '0;
      cap_taken <= 1'b0;
      cap_tgt   <= '0;
    end else if (accept) begin
      cap_pc    <= upd_pc[31:2];
      cap_taken <= upd_taken;
      cap_tgt   <= upd_target[31:2];
    end
  end

  // Read-modify-write merge of the entry read in RD.
  always_comb begin
    new_ent = '0;
    do_wr   = 1'b0;
    if (doutb[VLD_B] && doutb[TAG_HI:TAG_LO] == cap_tag) begin
      new_ent = entry_pack(1'b1, cap_tag,
                  cap_taken ? cap_tgt : doutb[TGT_HI:TGT_LO],
                  ctr_next(doutb[1:0], cap_taken));
      do_wr   = 1'b1;
    end else if (cap_taken) begin
      new_ent = entry_pack(1'b1, cap_tag, cap_tgt, 2'b10);
      do_wr   = 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    clr_nx    = clr_idx;
    web       = '0;
    addrb     = cap_pc[INDEX_W-1:0];
    dinb      = '0;
    upd_ready = 1'b0;
    init_busy = 1'b0;
    unique case (state)
      INIT: begin
        init_busy = 1'b1;
        web       = '1;
        addrb     = clr_idx;
        clr_nx    = clr_idx + 1'b1;
        if (&clr_idx)
          state_nx = IDLE;
      end
      IDLE: begin
        upd_ready = 1'b1;
        if (upd_valid)
          state_nx = RD;
      end
      RD: state_nx = MOD;
      MOD: begin
        dinb     = new_ent;
        web      = do_wr ? '1 : '0;
        state_nx = IDLE;
      end
    endcase
    if (flush) begin
      state_nx = INIT;
      clr_nx   = '0;
      web      = '0;
    end
  end

  // Same-index write in the lookup cycle: RAM returns old data, so forward.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lk_q     <= 1'b0;
      blk_q    <= 1'b0;
      fwd_q    <= 1'b0;
      lk_tag_q <= '0;
      fwd_d_q  <= '0;
    end else begin
      lk_q     <= lk_valid;
      blk_q    <= (state == INIT) | flush;
      fwd_q    <= lk_valid & (|web) & (addrb == lk_pc[8:2]);
      lk_tag_q <= lk_pc[31:9];
      fwd_d_q  <= dinb;
    end
  end

  assign ent = fwd_q ? fwd_d_q : douta;
  assign hit = lk_q & ~blk_q & ent[VLD_B] &
               (ent[TAG_HI:TAG_LO] == lk_tag_q);

  assign rsp_valid  = lk_q;
  assign rsp_hit    = hit;
  assign rsp_taken  = hit & ent[1];
  assign rsp_target = hit ? {ent[TGT_HI:TGT_LO], 2'b00} : 32'h0;

endmodule
